// File: rtl/kanagawa_loop_generator_if.sv
// Show-ahead FIFO read port: the master presents empty/data, the slave pulls rden.
interface kanagawa_loop_generator_if #(
  parameter int WIDTH = 128
);
  logic             empty;
  logic [WIDTH-1:0] data;
  logic             rden;

  modport master (output empty, output data, input rden);
  modport slave  (input empty, input data, output rden);
endinterface

// File: rtl/kanagawa_loop_generator.sv
// Expands each upstream record into max_thread_id+1 copies with the counter field set to 0..max.
// Define KANAGAWA_LOOP_GENERATOR_CHECKS_EN to enable simulation-only protocol assertions.
module kanagawa_loop_generator #(
  parameter int TOTAL_WIDTH               = 128,
  parameter int COUNTER_WIDTH             = 32,
  parameter int HAS_LITERAL_MAX_THREAD_ID = 0,
  parameter int LITERAL_MAX_THREAD_ID     = 0,
  parameter int OFFSET                    = 0,
  parameter int ONLY_ONE_THREAD_OFFSET    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  kanagawa_loop_generator_if.slave    up,
  kanagawa_loop_generator_if.master   dn,
  output logic                        underflow_out
);

  if ((ONLY_ONE_THREAD_OFFSET >= OFFSET) &&
      (ONLY_ONE_THREAD_OFFSET < OFFSET + COUNTER_WIDTH)) begin : g_bad_offset
    $error("only_one_thread bit overlaps the counter field");
  end

  logic                     valid_q, valid_d;
  logic [TOTAL_WIDTH-1:0]   rec_q, rec_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] maxr_q, maxr_d;
  logic                     one_q, one_d;
  logic                     underflow_q, underflow_d;
  logic                     last, pop, load;
  logic [TOTAL_WIDTH-1:0]   out_dat;

  always_comb begin
    last        = one_q | (cnt_q == maxr_q);
    pop         = dn.rden & valid_q;
    // No upstream pop while in reset so a queued record survives it.
    load        = !rst & !up.empty & (!valid_q | (pop & last));
    valid_d     = valid_q;
    rec_d       = rec_q;
    cnt_d       = cnt_q;
    maxr_d      = maxr_q;
    one_d       = one_q;
    underflow_d = dn.rden & !valid_q;
    if (load) begin
      rec_d   = up.data;
      cnt_d   = '0;
      valid_d = 1'b1;
      if (HAS_LITERAL_MAX_THREAD_ID != 0) begin
        maxr_d = COUNTER_WIDTH'(LITERAL_MAX_THREAD_ID);
        one_d  = (LITERAL_MAX_THREAD_ID == 0);
      end else begin
        maxr_d = up.data[OFFSET +: COUNTER_WIDTH];
        one_d  = up.data[ONLY_ONE_THREAD_OFFSET];
      end
    end else if (pop & !last) begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end else if (pop & last) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    out_dat = rec_q;
    out_dat[OFFSET +: COUNTER_WIDTH] = cnt_q;
  end

  assign up.rden       = load;
  assign dn.empty      = !valid_q;
  assign dn.data       = out_dat;
  assign underflow_out = underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rec_q       <= rec_d;
      cnt_q       <= cnt_d;
      maxr_q      <= maxr_d;
      one_q       <= one_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef KANAGAWA_LOOP_GENERATOR_CHECKS_EN
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dn.rden && !valid_q))
    else $error("rden_in asserted while empty_out=1");
  a_one_thread_cnt: assert property (@(posedge clk) disable iff (rst)
      !((HAS_LITERAL_MAX_THREAD_ID == 0) && load && up.data[ONLY_ONE_THREAD_OFFSET] &&
        (up.data[OFFSET +: COUNTER_WIDTH] != '0)))
    else $error("only_one_thread set with nonzero counter field");
  a_no_x: assert property (@(posedge clk) disable iff (rst) !$isunknown({up.empty, dn.rden}))
    else $error("X on empty_in/rden_in");
`endif

endmodule

// File: tb/tb_kanagawa_loop_generator.sv
// Directed bench with queue scoreboards for a runtime-count instance (A) and a literal-count instance (B).
module tb_kanagawa_loop_generator;

  localparam int TW = 128;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uf_a, uf_b;

  always #5 clk = ~clk;

  kanagawa_loop_generator_if #(.WIDTH(TW)) a_up ();
  kanagawa_loop_generator_if #(.WIDTH(TW)) a_dn ();
  kanagawa_loop_generator_if #(.WIDTH(TW)) b_up ();
  kanagawa_loop_generator_if #(.WIDTH(TW)) b_dn ();

  kanagawa_loop_generator #(
    .TOTAL_WIDTH(TW), .COUNTER_WIDTH(CW), .HAS_LITERAL_MAX_THREAD_ID(0),
    .LITERAL_MAX_THREAD_ID(0), .OFFSET(0), .ONLY_ONE_THREAD_OFFSET(32)
  ) dut_a (.clk(clk), .rst(rst), .up(a_up.slave), .dn(a_dn.master), .underflow_out(uf_a));

  kanagawa_loop_generator #(
    .TOTAL_WIDTH(TW), .COUNTER_WIDTH(CW), .HAS_LITERAL_MAX_THREAD_ID(1),
    .LITERAL_MAX_THREAD_ID(3), .OFFSET(0), .ONLY_ONE_THREAD_OFFSET(32)
  ) dut_b (.clk(clk), .rst(rst), .up(b_up.slave), .dn(b_dn.master), .underflow_out(uf_b));

  logic [TW-1:0] up_q0[$], up_q1[$], exp_q0[$], exp_q1[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_out0 = 0;
  int  n_out1 = 0;
  bit  rst_req = 1'b1;
  bit  up_pop0 = 1'b0;
  bit  up_pop1 = 1'b0;

  // Record layout: [31:0] counter, [32] only_one_thread, [127:64] payload.
  function automatic logic [TW-1:0] mk(input logic [63:0] dat, input logic one, input logic [31:0] cnt);
    mk = {dat, 31'b0, one, cnt};
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push a runtime-count record to A and queue its expected expansion.
  task automatic push_a(input logic [63:0] dat, input logic one, input int max, input int n_exp);
    up_q0.push_back(mk(dat, one, max));
    for (int k = 0; k < n_exp; k++) exp_q0.push_back(mk(dat, one, k));
  endtask

  // One clock of stimulus for instance d; the other instance idles.
  task automatic cycle(input int d, input bit rd, input bit up_ok);
    @(negedge clk);
    if (up_pop0) void'(up_q0.pop_front());
    if (up_pop1) void'(up_q1.pop_front());
    rst = rst_req;
    a_up.empty = !(d == 0 && up_ok && up_q0.size() != 0);
    a_up.data  = (up_q0.size() != 0) ? up_q0[0] : '0;
    a_dn.rden  = (d == 0) && rd;
    b_up.empty = !(d == 1 && up_ok && up_q1.size() != 0);
    b_up.data  = (up_q1.size() != 0) ? up_q1[0] : '0;
    b_dn.rden  = (d == 1) && rd;
    #1;
    up_pop0 = a_up.rden;
    up_pop1 = b_up.rden;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst && a_dn.rden && !a_dn.empty) begin
      n_out0++;
      if (exp_q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_output: got %h expected none", a_dn.data);
      end else chk("a_output", a_dn.data, exp_q0.pop_front());
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst && b_dn.rden && !b_dn.empty) begin
      n_out1++;
      if (exp_q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_output: got %h expected none", b_dn.data);
      end else chk("b_output", b_dn.data, exp_q1.pop_front());
    end
  end

  initial begin
    int budget, us, ds, base;
    bit rd, upok;
    a_up.empty = 1'b1; a_up.data = '0; a_dn.rden = 1'b0;
    b_up.empty = 1'b1; b_up.data = '0; b_dn.rden = 1'b0;

    // Reset with a record already waiting: nothing may be popped or shown.
    push_a(64'h77, 1'b1, 0, 1);
    rst_req = 1'b1;
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("reset_rden_out", TW'(a_up.rden), TW'(0));
    chk("reset_empty_out", TW'(a_dn.empty), TW'(1));
    chk("reset_underflow", TW'(uf_a), TW'(0));

    // Force single: only_one_thread=1, counter 0 -> one output index 0.
    rst_req = 1'b0;
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("load_latency_empty", TW'(a_dn.empty), TW'(0));
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    chk("single_then_empty", TW'(a_dn.empty), TW'(1));

    // Underflow: one-cycle pulse, state unchanged.
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    chk("underflow_pulse", TW'(uf_a), TW'(1));
    chk("underflow_state", TW'(a_dn.empty), TW'(1));
    cycle(0, 0, 0);
    chk("underflow_clear", TW'(uf_a), TW'(0));

    // Back-to-back: max=2 then max=0 -> 0,1,2,0 with no bubble.
    push_a(64'hB2, 1'b0, 2, 3);
    push_a(64'hB0, 1'b0, 0, 1);
    cycle(0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 1);
      chk($sformatf("b2b_no_bubble_%0d", k), TW'(a_dn.empty), TW'(0));
    end
    cycle(0, 0, 1);
    chk("b2b_drained", TW'(a_dn.empty), TW'(1));

    // Reset mid-expansion: max=9, pop 3, reset, next record starts at 0.
    push_a(64'h99, 1'b0, 9, 3);
    cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1);
    rst_req = 1'b1;
    cycle(0, 0, 1);
    rst_req = 1'b0;
    cycle(0, 0, 1);
    chk("midreset_empty", TW'(a_dn.empty), TW'(1));
    push_a(64'hAB, 1'b0, 2, 3);
    cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1);
    cycle(0, 0, 0);
    chk("post_reset_drained", TW'(a_dn.empty), TW'(1));

    // Literal mode (max=3): counter 0x55 and only_one_thread are ignored.
    up_q1.push_back(mk(64'h5A5A, 1'b0, 32'h55));
    for (int k = 0; k < 4; k++) exp_q1.push_back(mk(64'h5A5A, 1'b0, k));
    up_q1.push_back(mk(64'hC3C3, 1'b1, 32'h55));
    for (int k = 0; k < 4; k++) exp_q1.push_back(mk(64'hC3C3, 1'b1, k));
    cycle(1, 0, 1);
    for (int k = 0; k < 8; k++) cycle(1, 1, 1);
    cycle(1, 0, 0);
    chk("literal_drained", TW'(b_dn.empty), TW'(1));
    chk("literal_out_count", TW'(n_out1), TW'(8));

    // Basic expansion with random stalls on both sides.
    base = n_out0;
    for (int i = 0; i < 100; i++) push_a(64'(i + 3), (i == 0), i, i + 1);
    budget = 80000; us = 0; ds = 0;
    while ((exp_q0.size() != 0) && (budget > 0)) begin
      rd   = (ds == 0);
      upok = (us == 0);
      if (ds > 0) ds--; else if ($urandom_range(0, 3) == 0) ds = $urandom_range(1, 10);
      if (us > 0) us--; else if ($urandom_range(0, 3) == 0) us = $urandom_range(1, 10);
      cycle(0, rd, upok);
      budget--;
    end
    if (budget == 0) begin
      n_chk++; n_fail++;
      $display("FAIL basic_timeout: %0d outputs still pending, required 0", exp_q0.size());
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("basic_out_count", TW'(n_out0 - base), TW'(5050));
    chk("basic_drained", TW'(a_dn.empty), TW'(1));
    chk("upstream_consumed", TW'(up_q0.size()), TW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
